sprite_cmd_queue: RTL and testbench
===================================

// Module: sprite_cmd_queue
// PURPOSE
//  Upstream command stage for all sprite display blocks (clouds, background, characters).
//  Buffers host 32-bit sprite command words in a FIFO and issues them one per cycle on the
//  shared writedata bus. Forces each command's buffer-select bit to the current back buffer.
//  Defers buffer-swap (flush) commands to vertical blank, so a displayed frame never tears.
// PARAMETERS
//  DEPTH        16       FIFO depth in words; power of two, >= 4
//  VBLANK_LINE  10'd480  first vcount value treated as vertical blank
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-low reset
//  wr_valid       in   1   host presents a command word
//  wr_data        in   32  command: [31:26] sub_comp, [25:21] child, [20:17] info,
//                          [16:14] type, [13] pp_selc, [12:0] msg
//  wr_ready       out  1   FIFO can accept; a word is pushed when wr_valid && wr_ready
//  hcount         in   10  VGA horizontal counter
//  vcount         in   10  VGA vertical counter
//  writedata_out  out  32  command bus to the display blocks; registered
//  pp_active      out  1   buffer currently displayed (front)
//  fifo_level     out  $clog2(DEPTH)+1  words currently queued
//  overflow       out  1   sticky: wr_valid seen while wr_ready=0
// BEHAVIOUR
//  Reset (async, active-low): FIFO emptied, writedata_out=32'h0, pp_active=0,
//    fifo_level=0, overflow=0, wr_ready=1, state=ISSUE, frame_armed=1.
//    Asserting reset mid-operation discards all queued words.
//  Idle word: 32'h0 (info=0), which every display block ignores.
//    Any cycle without an issued command drives the idle word, so each command is seen exactly once.
//  wr_ready = (fifo_level != DEPTH). Push and pop in the same cycle leaves the level unchanged.
//    A push while full is dropped and sets overflow, which clears only on reset.
//  Latency: a word pushed into an empty FIFO in cycle N is popped in N+1.
//    It appears on writedata_out in N+2. Throughput is 1 word/cycle.
//  Rewrite at issue: bit[13] is replaced with ~pp_active. All other bits pass unchanged.
//  vblank = (vcount >= VBLANK_LINE).
//    frame_armed is set in any cycle with vcount < VBLANK_LINE.
//    frame_armed is cleared when a flush issues.
//  FSM:
//   ISSUE: FIFO empty -> drive the idle word.
//     Head info != 4'hF -> pop and issue it.
//     Head info == 4'hF -> go to WAIT_VB without popping; drive the idle word.
//   WAIT_VB: drive the idle word and hold the head.
//     When vblank && frame_armed -> pop, issue the flush with bit[13] = ~pp_active,
//     toggle pp_active in the same cycle writedata_out updates, clear frame_armed, go to ISSUE.
//  Ordering: strict FIFO. Normal writes behind a pending flush wait for it.
//    A second flush in the same blank waits for the next frame's blank, so there is at most one swap per frame.
//  Boundary cases:
//    A flush head arriving exactly at vcount == VBLANK_LINE issues two cycles later if armed.
//    A FIFO that goes empty while in WAIT_VB is impossible, because the head is held.
//    Pushes continue normally during WAIT_VB until the FIFO is full.
//  hcount is used only to qualify the arm point (vcount == 0 && hcount == 0 also sets frame_armed).
// STRUCTURE
//  Package sprite_cmd_pkg:
//    field offsets/widths of the command word
//    INFO_WRITE = 4'h1, INFO_FLUSH = 4'hF, IDLE_WORD = 32'h0
//    typedef enum {ISSUE, WAIT_VB} cmdq_state_t
//  Sub-module cmd_fifo: synchronous FIFO (DEPTH, width 32).
//    Provides push/pop, head word (first-word-fall-through), level, full/empty, and the same async active-low reset.
//  The top level holds the FSM, bit[13] rewrite, pp_active, frame_armed, overflow and the output register.
// TESTING
//  1 Push 3 writes (info=1, type=2) back-to-back into an empty FIFO at vcount=100.
//    -> They appear on consecutive cycles starting at N+2 with bit13=1, then 32'h0.
//  2 Push a flush at vcount=100.
//    -> writedata_out stays 0 until vcount=480; then one cycle of info=F with bit13=1; pp_active goes 0->1.
//  3 Push a flush, a write, and a flush in one frame.
//    -> First flush issues at line 480 and the write follows with bit13=0.
//    -> Second flush waits for the next frame's line 480; pp_active returns to 0.
//  4 Push DEPTH+2 words while a flush is blocked at the head.
//    -> wr_ready=0 at level=DEPTH; the last 2 are dropped; overflow=1.
//    -> All DEPTH words are later issued in order.
//  5 Push and pop in the same cycle at level=5.
//    -> Level stays 5 and no word is lost or duplicated (scoreboard).
//  6 Assert reset while in WAIT_VB with 4 queued.
//    -> Immediately writedata_out=0, level=0, pp_active=0; no queued word is issued after release.

Source files
------------

// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command queue: command-word field layout,
// special info codes, the idle word and the issue FSM state type.
package sprite_cmd_pkg;

   // Command word layout: [31:26] sub_comp, [25:21] child, [20:17] info,
   // [16:14] type, [13] pp_selc, [12:0] msg
   localparam int unsigned MSG_LSB      = 0;
   localparam int unsigned MSG_W        = 13;
   localparam int unsigned PP_SELC_BIT  = 13;
   localparam int unsigned TYPE_LSB     = 14;
   localparam int unsigned TYPE_W       = 3;
   localparam int unsigned INFO_LSB     = 17;
   localparam int unsigned INFO_W       = 4;
   localparam int unsigned CHILD_LSB    = 21;
   localparam int unsigned CHILD_W      = 5;
   localparam int unsigned SUB_COMP_LSB = 26;
   localparam int unsigned SUB_COMP_W   = 6;

   localparam logic [3:0]  INFO_WRITE = 4'h1;
   localparam logic [3:0]  INFO_FLUSH = 4'hF;
   localparam logic [31:0] IDLE_WORD  = 32'h0000_0000;

   typedef enum logic [0:0] {
      ISSUE   = 1'b0,
      WAIT_VB = 1'b1
   } cmdq_state_t;

   // Extract the info field of a command word.
   function automatic logic [3:0] cmd_info(input logic [31:0] word);
      return word[INFO_LSB +: INFO_W];
   endfunction

   // Replace the buffer-select bit of a command word.
   function automatic logic [31:0] set_pp_selc(input logic [31:0] word, input logic pp);
      logic [31:0] res;
      res              = word;
      res[PP_SELC_BIT] = pp;
      return res;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is visible whenever
// the FIFO is non-empty; pushes when full and pops when empty are ignored.
module cmd_fifo #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push_s, do_pop_s;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == {LW{1'b0}});
   assign head  = mem_q[rd_ptr_q];
   assign level = level_q;

   // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_comb begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO state registers; reset discards all stored words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/sprite_cmd_queue.sv
// Sprite command queue: buffers host command words, issues one per cycle on the
// shared writedata bus with the buffer-select bit forced to the back buffer, and
// holds buffer-swap (flush) commands until vertical blank, at most one per frame.
module sprite_cmd_queue
   import sprite_cmd_pkg::*;
#(
   parameter  int unsigned DEPTH       = 16,
   parameter  logic [9:0]  VBLANK_LINE = 10'd480,
   localparam int unsigned LW          = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_valid,
   input  logic [31:0]   wr_data,
   output logic          wr_ready,
   input  logic [9:0]    hcount,
   input  logic [9:0]    vcount,
   output logic [31:0]   writedata_out,
   output logic          pp_active,
   output logic [LW-1:0] fifo_level,
   output logic          overflow
);

   cmdq_state_t   state_q, state_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          pp_q, pp_d;
   logic          armed_q, armed_d;
   logic          ovf_q, ovf_d;
   logic          push_s, pop_s, flush_issue_s;
   logic          vblank_s, arm_s;
   logic [31:0]   head_s;
   logic [LW-1:0] level_s;
   logic          full_s, empty_s;

   assign wr_ready      = !full_s;
   assign push_s        = wr_valid && !full_s;
   assign vblank_s      = (vcount >= VBLANK_LINE);
   assign arm_s         = (vcount < VBLANK_LINE) || ((vcount == 10'd0) && (hcount == 10'd0));
   assign writedata_out = wdata_q;
   assign pp_active     = pp_q;
   assign fifo_level    = level_s;
   assign overflow      = ovf_q;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (wr_data),
      .head      (head_s),
      .level     (level_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   // Issue FSM: pop and rewrite normal words, park on a flush head until an armed vblank.
   always_comb begin
      state_d       = state_q;
      wdata_d       = IDLE_WORD;
      pp_d          = pp_q;
      pop_s         = 1'b0;
      flush_issue_s = 1'b0;
      case (state_q)
         ISSUE: begin
            if (empty_s) begin
               state_d = ISSUE;
            end else if (cmd_info(head_s) == INFO_FLUSH) begin
               state_d = WAIT_VB;
            end else begin
               pop_s   = 1'b1;
               wdata_d = set_pp_selc(head_s, ~pp_q);
            end
         end
         WAIT_VB: begin
            if (vblank_s && armed_q) begin
               pop_s         = 1'b1;
               flush_issue_s = 1'b1;
               wdata_d       = set_pp_selc(head_s, ~pp_q);
               pp_d          = ~pp_q;
               state_d       = ISSUE;
            end else begin
               state_d = WAIT_VB;
            end
         end
         default: begin
            state_d = ISSUE;
         end
      endcase
   end

   // Frame arming (one swap per frame) and sticky overflow on dropped pushes.
   always_comb begin
      armed_d = armed_q;
      ovf_d   = ovf_q;
      if (flush_issue_s) begin
         armed_d = 1'b0;
      end else if (arm_s) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end
      if (wr_valid && full_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ISSUE;
         wdata_q <= IDLE_WORD;
         pp_q    <= 1'b0;
         armed_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wdata_q <= wdata_d;
         pp_q    <= pp_d;
         armed_q <= armed_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Self-checking bench for sprite_cmd_queue: a scoreboard of pushed words is
// compared against every non-idle output word, with a reference model of the
// buffer-select rewrite, pp_active and frame arming, plus directed timing checks.
module tb_sprite_cmd_queue;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          reset;
   logic          wr_valid;
   logic [31:0]   wr_data;
   logic          wr_ready;
   logic [9:0]    hcount;
   logic [9:0]    vcount;
   logic [31:0]   writedata_out;
   logic          pp_active;
   logic [LW-1:0] fifo_level;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_q[$];
   logic        model_pp;
   logic        model_armed;
   logic        arm_pend;
   logic [9:0]  vc_last;

   sprite_cmd_queue #(.DEPTH(DEPTH), .VBLANK_LINE(10'd480)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .hcount        (hcount),
      .vcount        (vcount),
      .writedata_out (writedata_out),
      .pp_active     (pp_active),
      .fifo_level    (fifo_level),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] info, input logic [2:0] typ,
                                      input logic pp, input logic [12:0] msg);
      return {6'd3, 5'd4, info, typ, pp, msg};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w, input bit accept);
      wr_valid = 1'b1;
      wr_data  = w;
      if (accept) sb_q.push_back(w);
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sb_q.delete();
      model_pp    = 1'b0;
      model_armed = 1'b1;
      arm_pend    = 1'b0;
      #1;
      chk("rst_wdata", writedata_out, 32'h0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_pp", 32'(pp_active), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_ready", 32'(wr_ready), 32'd1);
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Scoreboard monitor: every non-idle output word must be the next expected word.
   always @(negedge clk) begin
      logic [31:0] raw;
      logic [31:0] exp;
      if (reset) begin
         if (writedata_out != 32'h0) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_word", writedata_out, 32'h0);
            end else begin
               raw     = sb_q.pop_front();
               exp     = raw;
               exp[13] = ~model_pp;
               chk("sb_word", writedata_out, exp);
               if (raw[20:17] == 4'hF) begin
                  chk("flush_in_vblank", 32'(vc_last >= 10'd480), 32'd1);
                  chk("flush_armed", 32'(model_armed), 32'd1);
                  model_pp    = ~model_pp;
                  model_armed = 1'b0;
               end
               chk("sb_pp", 32'(pp_active), 32'(model_pp));
            end
         end
         model_armed = model_armed | arm_pend;
         arm_pend    = (vcount < 10'd480);
         vc_last     = vcount;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nz;
      logic [31:0] w0, w1, w2, f1, wa, f2;
      reset    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 32'h0;
      hcount   = 10'd5;
      vcount   = 10'd100;
      vc_last  = 10'd100;
      #2;
      do_reset();

      // Test 1: three writes back-to-back, latency N+2, then idle
      w0 = mk(4'h1, 3'd2, 1'b0, 13'd10);
      w1 = mk(4'h1, 3'd2, 1'b1, 13'd11);
      w2 = mk(4'h1, 3'd2, 1'b0, 13'd12);
      push(w0, 1'b1);
      chk("t1_lat_idle", writedata_out, 32'h0);
      push(w1, 1'b1);
      chk("t1_w0", writedata_out, w0 | 32'h0000_2000);
      push(w2, 1'b1);
      chk("t1_w1", writedata_out, w1 | 32'h0000_2000);
      tick();
      chk("t1_w2", writedata_out, w2 | 32'h0000_2000);
      tick();
      chk("t1_idle", writedata_out, 32'h0);

      // Test 2: flush waits for line 480
      f1 = mk(4'hF, 3'd0, 1'b0, 13'd20);
      push(f1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t2_hold", writedata_out, 32'h0);
      end
      vcount = 10'd480;
      tick();
      chk("t2_flush", writedata_out, f1 | 32'h0000_2000);
      chk("t2_pp", 32'(pp_active), 32'd1);
      tick();
      chk("t2_idle", writedata_out, 32'h0);
      vcount = 10'd100;
      tick();

      // Test 3: flush, write, flush in one frame
      do_reset();
      vcount = 10'd100;
      f1 = mk(4'hF, 3'd1, 1'b0, 13'd30);
      wa = mk(4'h1, 3'd2, 1'b1, 13'd31);
      f2 = mk(4'hF, 3'd1, 1'b1, 13'd32);
      push(f1, 1'b1);
      push(wa, 1'b1);
      push(f2, 1'b1);
      tick();
      vcount = 10'd480;
      tick();
      chk("t3_f1", writedata_out, f1 | 32'h0000_2000);
      chk("t3_pp1", 32'(pp_active), 32'd1);
      tick();
      chk("t3_w", writedata_out, wa & ~32'h0000_2000);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t3_f2_wait", writedata_out, 32'h0);
      end
      vcount = 10'd100;
      tick();
      vcount = 10'd480;
      tick();
      chk("t3_f2", writedata_out, f2 & ~32'h0000_2000);
      chk("t3_pp0", 32'(pp_active), 32'd0);

      // Test 4: fill behind a blocked flush, drop two, drain in order
      vcount = 10'd100;
      tick();
      push(mk(4'hF, 3'd2, 1'b0, 13'd40), 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (i == DEPTH - 1) begin
            chk("t4_level_full", 32'(fifo_level), DEPTH);
            chk("t4_ready0", 32'(wr_ready), 32'd0);
            chk("t4_ovf_before", 32'(overflow), 32'd0);
         end
         push(mk(4'h1, 3'd2, 1'b0, 13'(100 + i)), i < DEPTH - 1);
      end
      chk("t4_ovf", 32'(overflow), 32'd1);
      chk("t4_level_hold", 32'(fifo_level), DEPTH);
      vcount = 10'd480;
      for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
      chk("t4_drained", 32'(sb_q.size()), 32'd0);
      tick();
      chk("t4_level0", 32'(fifo_level), 32'd0);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);

      // Test 5: simultaneous push and pop at level 5
      vcount = 10'd100;
      tick();
      push(mk(4'hF, 3'd3, 1'b0, 13'd50), 1'b1);
      for (int i = 0; i < 4; i++) push(mk(4'h1, 3'd2, 1'b0, 13'(51 + i)), 1'b1);
      chk("t5_level5", 32'(fifo_level), 32'd5);
      vcount = 10'd480;
      for (int i = 0; i < 4; i++) begin
         push(mk(4'h1, 3'd4, 1'b1, 13'(60 + i)), 1'b1);
         chk("t5_level_steady", 32'(fifo_level), 32'd5);
      end
      for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick();
      chk("t5_drained", 32'(sb_q.size()), 32'd0);

      // Test 6: reset while waiting for vblank with four words queued
      vcount = 10'd100;
      tick();
      push(mk(4'hF, 3'd0, 1'b0, 13'd70), 1'b1);
      for (int i = 0; i < 3; i++) push(mk(4'h1, 3'd2, 1'b0, 13'(71 + i)), 1'b1);
      tick();
      tick();
      chk("t6_level4", 32'(fifo_level), 32'd4);
      do_reset();
      vcount = 10'd480;
      nz = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (writedata_out != 32'h0) nz++;
      end
      chk("t6_no_issue", 32'(nz), 32'd0);
      chk("t6_level0", 32'(fifo_level), 32'd0);

      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
